pipe_trace_buffer: RTL and testbench
====================================

Name: pipe_trace_buffer

Overview:
Synthesizable on-chip trace buffer for the 5-stage RISC-V pipeline. Captures one record per retired writeback (PC, rd, write data, cycle stamp) into a circular buffer of DEPTH entries. Supports fill, wrap and PC-trigger capture modes, with a pop-style readout port. It replaces per-cycle console dumps for long runs and for silicon/FPGA debug. It sits beside the MEM/WB register and is fed by the writeback-stage signals.

Parameters:
XLEN, 64, width of wb_data and PC fields
DEPTH, 32, number of entries; power of 2, minimum 4
CYC_W, 32, width of the cycle stamp
FILTER_X0, 1, when 1, records with wb_rd==0 are not captured

Ports:
clk  in  1  clock; all state changes on the rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
wb_valid  in  1  a writeback retires this cycle
wb_pc  in  XLEN  PC of the retiring instruction
wb_rd  in  5  destination register
wb_data  in  XLEN  value written to the register file
arm  in  1  start or restart capture (1-cycle pulse)
mode  in  2  0=FILL, 1=WRAP, 2=TRIG, 3=reserved (behaves as FILL); sampled on arm
trig_pc  in  XLEN  trigger PC; sampled on arm
post_count  in  clog2(DEPTH)+1  number of records kept after the trigger; sampled on arm
stop  in  1  ends capture in WRAP mode
rd_req  in  1  pop the oldest entry
rd_valid  out  1  rd_* outputs carry a popped entry
rd_pc  out  XLEN  popped PC
rd_rd  out  5  popped rd
rd_data  out  XLEN  popped data
rd_cycle  out  CYC_W  popped cycle stamp
count  out  clog2(DEPTH)+1  entries currently held
overflow  out  1  sticky; at least one entry was overwritten
state  out  2  0=IDLE, 1=CAPTURE, 2=POST, 3=DONE

Behaviour:
- Reset (asynchronous):
  - state=IDLE; count=0; overflow=0; rd_valid=0.
  - rd_pc, rd_rd, rd_data, rd_cycle = 0.
  - Write and read pointers = 0; cycle counter = 0.
  - These values apply immediately on assertion, including mid-capture or mid-readout.
- Qualified record: wb_valid && !(FILTER_X0 && wb_rd==0). Records are written only in CAPTURE or POST.
- arm (any state):
  - Clears pointers, count, overflow and the cycle counter.
  - Latches mode, trig_pc and post_count. post_count is clamped to DEPTH-1 so the trigger entry is always kept.
  - state=CAPTURE on the next cycle. Records presented in the arm cycle are not captured.
- Cycle counter: increments every cycle in CAPTURE or POST and saturates at all-ones. A record's stamp is the counter value in its capture cycle; the first cycle after arm has stamp 0.
- Write: the record is stored at wptr, and wptr increments modulo DEPTH.
  - count<DEPTH: count increments.
  - count==DEPTH: the oldest entry is overwritten, rptr advances, overflow=1.
- FILL: the write that makes count==DEPTH moves state to DONE on the next cycle. Later records are dropped.
- WRAP: wraps indefinitely.
  - stop moves state to DONE on the next cycle.
  - A record in the same cycle as stop is still captured.
  - stop in other modes or states is ignored.
- TRIG: wraps while in CAPTURE.
  - A qualified record with wb_pc==trig_pc is captured and state moves to POST; remaining = post_count.
  - With post_count=0, state goes straight to DONE instead of POST.
  - In POST, each captured record decrements remaining. The record that brings it to 0 moves state to DONE on the next cycle.
  - Matches seen during POST do not retrigger.
- DONE: capture is frozen. rd_req is honoured only in DONE.
  - rd_req with count>0: on the next cycle rd_valid=1, rd_* = entry at rptr, rptr increments, count decrements.
  - Back-to-back rd_req gives one entry per cycle.
  - rd_req with count==0: rd_valid=0 and nothing changes.
  - rd_valid lasts one cycle per pop. rd_* hold their last value otherwise.
  - rd_req in other states is ignored.
  - Reaching count==0 keeps state=DONE.
- Simultaneous arm and rd_req: arm wins, and no pop occurs.
- Storage: registered-read RAM or register array of width 2*XLEN+5+CYC_W.

Decomposition:
- Shared package pipe_trace_pkg:
  - state encoding (IDLE/CAPTURE/POST/DONE);
  - mode encoding (FILL/WRAP/TRIG);
  - trace-record struct {pc, rd, data, cycle}.
- One sub-module: trace_ram, a DEPTH x record single-write, single-registered-read memory.
- Control FSM, pointers and counters stay in pipe_trace_buffer.

Test Plan:
1. FILL, DEPTH=8, FILTER_X0=0: arm, then 10 records with pc=0x0..0x24 step 4 -> DONE after 8th record; count=8, overflow=0; 8 pops return pc 0x00..0x1C, stamps ascending; 9th pop gives rd_valid=0.
2. WRAP, DEPTH=8: arm, 12 records pc=0x00..0x2C, stop in the same cycle as the 12th -> count=8, overflow=1; pops return pc 0x10..0x2C.
3. TRIG, DEPTH=8, trig_pc=0x20, post_count=2: records pc 0x00..0x40 step 4 -> DONE after pc 0x28; pops return pc 0x0C..0x28; pc 0x2C onward not captured.
4. FILTER_X0=1: alternate wb_rd=0 and wb_rd=5 over 6 records -> count=3, all popped rd_rd=5; TRIG on a pc carried with rd=0 never fires (state stays CAPTURE).
5. Assert reset low mid-POST and again mid-readout -> state=0, count=0, rd_valid=0 immediately (before the next edge); after release, arm restarts cleanly with stamp 0.
6. DONE with count=3: rd_req and arm in the same cycle -> no rd_valid, state=CAPTURE, count=0; rd_req during CAPTURE is ignored.

Source files
------------

// File: rtl/pipe_trace_buffer_pkg.sv
// Shared types for the writeback trace buffer: FSM/mode encodings and the
// stored record layout.
package pipe_trace_pkg;

  // The record is sized for the widest supported configuration.
  // Narrower XLEN/CYC_W values are zero-extended into it.
  localparam int TRACE_PC_W  = 64;
  localparam int TRACE_CYC_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_POST    = 2'd2,
    ST_DONE    = 2'd3
  } trace_state_e;

  typedef enum logic [1:0] {
    MODE_FILL = 2'd0,
    MODE_WRAP = 2'd1,
    MODE_TRIG = 2'd2,
    MODE_RSVD = 2'd3
  } trace_mode_e;

  typedef struct packed {
    logic [TRACE_PC_W-1:0]  pc;
    logic [4:0]             rd;
    logic [TRACE_PC_W-1:0]  data;
    logic [TRACE_CYC_W-1:0] cycle;
  } trace_rec_t;

endpackage

// File: rtl/pipe_trace_buffer_if.sv
// Writeback feed and pop-style readout bundle between the pipeline/debug host
// (master) and the trace buffer (slave).
interface pipe_trace_buffer_if #(
  parameter int XLEN  = 64,
  parameter int CYC_W = 32
);
  logic            wb_valid;
  logic [XLEN-1:0] wb_pc;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;

  logic             rd_req;
  logic             rd_valid;
  logic [XLEN-1:0]  rd_pc;
  logic [4:0]       rd_rd;
  logic [XLEN-1:0]  rd_data;
  logic [CYC_W-1:0] rd_cycle;

  modport master (
    output wb_valid, wb_pc, wb_rd, wb_data, rd_req,
    input  rd_valid, rd_pc, rd_rd, rd_data, rd_cycle
  );

  modport slave (
    input  wb_valid, wb_pc, wb_rd, wb_data, rd_req,
    output rd_valid, rd_pc, rd_rd, rd_data, rd_cycle
  );
endinterface

// File: rtl/pipe_trace_buffer_ram.sv
// DEPTH x trace_rec_t storage: one write port, one registered read port whose
// output register holds its value until the next read.
module trace_ram
  import pipe_trace_pkg::*;
#(
  parameter int DEPTH = 32,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  trace_rec_t    wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output trace_rec_t    rdata
);

  trace_rec_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/pipe_trace_buffer.sv
// Writeback trace buffer: captures retired register writes into a circular
// buffer under FILL/WRAP/TRIG control and drains them through a pop port.
module pipe_trace_buffer
  import pipe_trace_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter int DEPTH     = 32,
  parameter int CYC_W     = 32,
  parameter int FILTER_X0 = 1,
  localparam int CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  pipe_trace_buffer_if.slave tif,
  input  logic               arm,
  input  logic [1:0]         mode,
  input  logic [XLEN-1:0]    trig_pc,
  input  logic [CNT_W-1:0]   post_count,
  input  logic               stop,
  output logic [CNT_W-1:0]   count,
  output logic               overflow,
  output logic [1:0]         state
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] MAX_POST = CNT_W'(DEPTH - 1);
  localparam logic [CYC_W-1:0] CYC_MAX  = '1;

  trace_state_e     state_q;
  trace_mode_e      mode_q;
  logic [XLEN-1:0]  trig_q;
  logic [CNT_W-1:0] post_q, rem_q, count_q;
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CYC_W-1:0] cyc_q;
  logic             ovf_q, rd_valid_q;
  logic             qual, capturing, wr_en, full, pop;
  trace_rec_t       wr_rec, rd_rec;

  always_comb begin
    qual      = tif.wb_valid && !((FILTER_X0 != 0) && (tif.wb_rd == 5'd0));
    capturing = (state_q == ST_CAPTURE) || (state_q == ST_POST);
    wr_en     = !arm && capturing && qual;
    full      = (count_q == FULL_CNT);
    pop       = !arm && (state_q == ST_DONE) && tif.rd_req && (count_q != '0);
    wr_rec       = '0;
    wr_rec.pc    = TRACE_PC_W'(tif.wb_pc);
    wr_rec.rd    = tif.wb_rd;
    wr_rec.data  = TRACE_PC_W'(tif.wb_data);
    wr_rec.cycle = TRACE_CYC_W'(cyc_q);
  end

  trace_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (wr_en),
    .waddr (wptr_q),
    .wdata (wr_rec),
    .re    (pop),
    .raddr (rptr_q),
    .rdata (rd_rec)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_FILL;
      trig_q     <= '0;
      post_q     <= '0;
      rem_q      <= '0;
      count_q    <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cyc_q      <= '0;
      ovf_q      <= 1'b0;
      rd_valid_q <= 1'b0;
    end else if (arm) begin
      state_q    <= ST_CAPTURE;
      mode_q     <= trace_mode_e'(mode);
      trig_q     <= trig_pc;
      post_q     <= (post_count > MAX_POST) ? MAX_POST : post_count;
      rem_q      <= '0;
      count_q    <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cyc_q      <= '0;
      ovf_q      <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= pop;
      if (capturing && cyc_q != CYC_MAX) cyc_q <= cyc_q + CYC_W'(1);
      // A write into a full buffer drops the oldest entry, so rptr follows wptr.
      if (wr_en) begin
        wptr_q <= wptr_q + AW'(1);
        if (full) begin
          rptr_q <= rptr_q + AW'(1);
          ovf_q  <= 1'b1;
        end else begin
          count_q <= count_q + CNT_W'(1);
        end
      end
      if (pop) begin
        rptr_q  <= rptr_q + AW'(1);
        count_q <= count_q - CNT_W'(1);
      end
      case (state_q)
        ST_CAPTURE: begin
          case (mode_q)
            MODE_WRAP: if (stop) state_q <= ST_DONE;
            MODE_TRIG: begin
              if (wr_en && tif.wb_pc == trig_q) begin
                if (post_q == '0) begin
                  state_q <= ST_DONE;
                end else begin
                  state_q <= ST_POST;
                  rem_q   <= post_q;
                end
              end
            end
            default: if (wr_en && count_q == FULL_CNT - CNT_W'(1)) state_q <= ST_DONE;
          endcase
        end
        ST_POST: begin
          if (wr_en) begin
            rem_q <= rem_q - CNT_W'(1);
            if (rem_q == CNT_W'(1)) state_q <= ST_DONE;
          end
        end
        default: ;
      endcase
    end
  end

  assign tif.rd_valid = rd_valid_q;
  assign tif.rd_pc    = rd_rec.pc[XLEN-1:0];
  assign tif.rd_rd    = rd_rec.rd;
  assign tif.rd_data  = rd_rec.data[XLEN-1:0];
  assign tif.rd_cycle = rd_rec.cycle[CYC_W-1:0];
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign state        = state_q;

endmodule

// File: tb/tb_pipe_trace_buffer.sv
// Scoreboard bench for pipe_trace_buffer: two instances (x0 filter off/on)
// share stimulus and are checked against a queue-based reference model.
module tb_pipe_trace_buffer;

  localparam int XLEN  = 64;
  localparam int DEPTH = 8;
  localparam int CYC_W = 32;
  localparam int CNT_W = 4;

  typedef struct {
    logic [63:0] pc;
    logic [4:0]  rd;
    logic [63:0] data;
    logic [31:0] cyc;
  } rec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic wb_valid, arm, stop, rd_req;
  logic [63:0] wb_pc, wb_data, trig_pc;
  logic [4:0]  wb_rd;
  logic [1:0]  mode;
  logic [CNT_W-1:0] post_count;

  logic [CNT_W-1:0] cnt0, cnt1;
  logic ovf0, ovf1;
  logic [1:0] st0, st1;

  int tests = 0;
  int fails = 0;

  // reference model state, one slot per instance (index 1 filters x0)
  rec_t   mb[2][$];
  rec_t   expq[2][$];
  int     m_state[2], m_mode[2], m_post[2], m_rem[2];
  logic [63:0] m_trig[2];
  bit     m_ovf[2], m_rdv[2];
  longint m_cyc[2];

  pipe_trace_buffer_if #(.XLEN(XLEN), .CYC_W(CYC_W)) if0 ();
  pipe_trace_buffer_if #(.XLEN(XLEN), .CYC_W(CYC_W)) if1 ();

  assign if0.wb_valid = wb_valid; assign if1.wb_valid = wb_valid;
  assign if0.wb_pc    = wb_pc;    assign if1.wb_pc    = wb_pc;
  assign if0.wb_rd    = wb_rd;    assign if1.wb_rd    = wb_rd;
  assign if0.wb_data  = wb_data;  assign if1.wb_data  = wb_data;
  assign if0.rd_req   = rd_req;   assign if1.rd_req   = rd_req;

  pipe_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .CYC_W(CYC_W), .FILTER_X0(0)) u_dut0 (
    .clk(clk), .reset(rst_n), .tif(if0), .arm(arm), .mode(mode), .trig_pc(trig_pc),
    .post_count(post_count), .stop(stop), .count(cnt0), .overflow(ovf0), .state(st0)
  );

  pipe_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .CYC_W(CYC_W), .FILTER_X0(1)) u_dut1 (
    .clk(clk), .reset(rst_n), .tif(if1), .arm(arm), .mode(mode), .trig_pc(trig_pc),
    .post_count(post_count), .stop(stop), .count(cnt1), .overflow(ovf1), .state(st1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset(input int k);
    mb[k].delete();
    expq[k].delete();
    m_state[k] = 0; m_mode[k] = 0; m_post[k] = 0; m_rem[k] = 0;
    m_trig[k] = '0; m_ovf[k] = 0; m_rdv[k] = 0; m_cyc[k] = 0;
  endtask

  task automatic model_step(input int k);
    bit   q;
    rec_t r;
    m_rdv[k] = 0;
    if (!rst_n) begin
      model_reset(k);
    end else if (arm) begin
      mb[k].delete();
      m_ovf[k] = 0; m_cyc[k] = 0;
      m_mode[k] = int'(mode); m_trig[k] = trig_pc;
      m_post[k] = (int'(post_count) > DEPTH - 1) ? DEPTH - 1 : int'(post_count);
      m_state[k] = 1;
    end else if (m_state[k] == 1 || m_state[k] == 2) begin
      q = wb_valid && !(k == 1 && wb_rd == 5'd0);
      if (q) begin
        r.pc = wb_pc; r.rd = wb_rd; r.data = wb_data; r.cyc = 32'(m_cyc[k]);
        if (mb[k].size() == DEPTH) begin
          void'(mb[k].pop_front());
          m_ovf[k] = 1;
        end
        mb[k].push_back(r);
      end
      if (m_state[k] == 2) begin
        if (q) begin
          m_rem[k]--;
          if (m_rem[k] == 0) m_state[k] = 3;
        end
      end else begin
        case (m_mode[k])
          1: if (stop) m_state[k] = 3;
          2: if (q && wb_pc == m_trig[k]) begin
               if (m_post[k] == 0) m_state[k] = 3;
               else begin m_state[k] = 2; m_rem[k] = m_post[k]; end
             end
          default: if (q && mb[k].size() == DEPTH) m_state[k] = 3;
        endcase
      end
      if (m_cyc[k] != 64'h0000_0000_FFFF_FFFF) m_cyc[k]++;
    end else if (m_state[k] == 3 && rd_req && mb[k].size() > 0) begin
      expq[k].push_back(mb[k].pop_front());
      m_rdv[k] = 1;
    end
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  always @(negedge rst_n) begin
    model_reset(0);
    model_reset(1);
  end

  task automatic check_dut(input int k, input logic [1:0] st, input logic [CNT_W-1:0] cnt,
                           input logic ovf, input logic rv, input logic [63:0] pc,
                           input logic [4:0] rd, input logic [63:0] data, input logic [31:0] cy);
    rec_t e;
    chk($sformatf("state%0d", k), 64'(st), 64'(m_state[k]));
    chk($sformatf("count%0d", k), 64'(cnt), 64'(mb[k].size()));
    chk($sformatf("overflow%0d", k), 64'(ovf), 64'(m_ovf[k]));
    chk($sformatf("rd_valid%0d", k), 64'(rv), 64'(m_rdv[k]));
    if (rv) begin
      if (expq[k].size() == 0) begin
        tests++; fails++;
        $display("FAIL pop%0d: rd_valid=1 but scoreboard empty at %0t", k, $time);
      end else begin
        e = expq[k].pop_front();
        chk($sformatf("rd_pc%0d", k), pc, e.pc);
        chk($sformatf("rd_rd%0d", k), 64'(rd), 64'(e.rd));
        chk($sformatf("rd_data%0d", k), data, e.data);
        chk($sformatf("rd_cycle%0d", k), 64'(cy), 64'(e.cyc));
      end
    end else begin
      expq[k].delete();
    end
  endtask

  always @(negedge clk) begin
    check_dut(0, st0, cnt0, ovf0, if0.rd_valid, if0.rd_pc, if0.rd_rd, if0.rd_data, if0.rd_cycle);
    check_dut(1, st1, cnt1, ovf1, if1.rd_valid, if1.rd_pc, if1.rd_rd, if1.rd_data, if1.rd_cycle);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    wb_valid = 0; arm = 0; stop = 0; rd_req = 0;
  endtask

  // arm cycle also presents a valid record, which must not be captured
  task automatic do_arm(input int md, input logic [63:0] tp, input int pcnt);
    arm = 1; mode = 2'(md); trig_pc = tp; post_count = CNT_W'(pcnt);
    wb_valid = 1; wb_pc = 64'hDEAD_0000; wb_rd = 5'd7; wb_data = {$urandom, $urandom};
    tick();
    idle_inputs();
  endtask

  task automatic rec(input logic [63:0] pc, input logic [4:0] rd, input logic st);
    wb_valid = 1; wb_pc = pc; wb_rd = rd; wb_data = {$urandom, $urandom}; stop = st;
    tick();
    wb_valid = 0; stop = 0;
  endtask

  task automatic drain(input int n);
    rd_req = 1;
    repeat (n) tick();
    rd_req = 0;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    wb_pc = '0; wb_rd = '0; wb_data = '0; mode = '0; trig_pc = '0; post_count = '0;
    rst_n = 1;
    #1 rst_n = 0;
    repeat (2) tick();
    #2 rst_n = 1;
    tick();

    // FILL: 10 records, only the first 8 kept, 9th pop empty
    do_arm(0, 64'h0, 0);
    for (int i = 0; i < 10; i++) rec(64'(i * 4), 5'(i + 1), 0);
    chk("fill_count", 64'(cnt0), 64'd8);
    chk("fill_state", 64'(st0), 64'd3);
    chk("fill_ovf", 64'(ovf0), 64'd0);
    drain(9);

    // WRAP: 12 records, stop with the 12th
    do_arm(1, 64'h0, 0);
    for (int i = 0; i < 12; i++) rec(64'(i * 4), 5'd3, (i == 11));
    tick();
    chk("wrap_count", 64'(cnt0), 64'd8);
    chk("wrap_ovf", 64'(ovf0), 64'd1);
    drain(8);

    // TRIG at 0x20 with two post records
    do_arm(2, 64'h20, 2);
    for (int i = 0; i <= 16; i++) rec(64'(i * 4), 5'd9, 0);
    chk("trig_state", 64'(st0), 64'd3);
    chk("trig_count", 64'(cnt0), 64'd8);
    drain(9);

    // x0 filtering and a trigger carried on rd=0
    do_arm(0, 64'h0, 0);
    for (int i = 0; i < 6; i++) rec(64'(i * 4), (i % 2 == 0) ? 5'd0 : 5'd5, 0);
    chk("filt_count1", 64'(cnt1), 64'd3);
    chk("filt_count0", 64'(cnt0), 64'd6);
    do_arm(2, 64'h100, 1);
    for (int i = 0; i < 3; i++) rec(64'h100, 5'd0, 0);
    chk("filt_trig_state1", 64'(st1), 64'd1);
    chk("filt_trig_state0", 64'(st0), 64'd3);

    // async reset mid-POST
    do_arm(2, 64'h8, 5);
    for (int i = 0; i < 5; i++) rec(64'(i * 4), 5'd4, 0);
    chk("post_state", 64'(st0), 64'd2);
    #2 rst_n = 0;
    #1;
    chk("rst_post_state", 64'(st0), 64'd0);
    chk("rst_post_count", 64'(cnt0), 64'd0);
    tick();
    #2 rst_n = 1;
    tick();

    // async reset mid-readout
    do_arm(0, 64'h0, 0);
    for (int i = 0; i < 8; i++) rec(64'(i * 8), 5'd2, 0);
    rd_req = 1;
    tick();
    rd_req = 0;
    chk("readout_valid", 64'(if0.rd_valid), 64'd1);
    #2 rst_n = 0;
    #1;
    chk("rst_rd_valid", 64'(if0.rd_valid), 64'd0);
    chk("rst_rd_pc", if0.rd_pc, 64'd0);
    chk("rst_rd_count", 64'(cnt0), 64'd0);
    tick();
    #2 rst_n = 1;
    tick();
    do_arm(2, 64'h40, 0);
    rec(64'h40, 5'd6, 0);
    rd_req = 1;
    tick();
    rd_req = 0;
    chk("restart_cycle", 64'(if0.rd_cycle), 64'd0);
    chk("restart_pc", if0.rd_pc, 64'h40);
    tick();

    // arm and rd_req together in DONE with 3 entries; rd_req in CAPTURE ignored
    do_arm(0, 64'h0, 0);
    for (int i = 0; i < 8; i++) rec(64'(i * 4), 5'd1, 0);
    rd_req = 1;
    repeat (5) tick();
    rd_req = 0;
    tick();
    chk("pre_arm_count", 64'(cnt0), 64'd3);
    arm = 1; rd_req = 1; mode = 2'd0; post_count = '0;
    tick();
    arm = 0;
    chk("arm_wins_valid", 64'(if0.rd_valid), 64'd0);
    chk("arm_wins_state", 64'(st0), 64'd1);
    chk("arm_wins_count", 64'(cnt0), 64'd0);
    for (int i = 0; i < 3; i++) rec(64'(i * 4), 5'd1, 0);
    rd_req = 0;
    tick();
    chk("capture_rd_ignored", 64'(cnt0), 64'd3);

    // randomized sessions
    for (int it = 0; it < 40; it++) begin
      int n;
      do_arm($urandom_range(0, 3), 64'($urandom_range(0, 15) * 4), $urandom_range(0, 15));
      n = $urandom_range(4, 40);
      for (int c = 0; c < n; c++) begin
        wb_valid = ($urandom_range(0, 3) != 0);
        wb_pc    = 64'($urandom_range(0, 15) * 4);
        wb_rd    = 5'($urandom_range(0, 3));
        wb_data  = {$urandom, $urandom};
        stop     = ($urandom_range(0, 15) == 0);
        rd_req   = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 63) == 0) begin
          arm = 1; mode = 2'($urandom_range(0, 3)); post_count = CNT_W'($urandom_range(0, 15));
        end
        tick();
        arm = 0;
      end
      idle_inputs();
      stop = 1;
      tick();
      stop = 0;
      for (int c = 0; c < 12; c++) begin
        rd_req = ($urandom_range(0, 3) != 0);
        tick();
      end
      rd_req = 0;
    end

    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
